// File: rtl/lieat_clint_ctrl_pkg.sv
// Shared CLINT definitions: data width, register offsets, timer bsel codes and
// the address decoder used by the CLINT bus controller.
package lieat_clint_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] OFF_MSIP    = 32'h0000_0000;
    localparam logic [XLEN-1:0] OFF_CMP_LO  = 32'h0000_4000;
    localparam logic [XLEN-1:0] OFF_CMP_HI  = 32'h0000_4004;
    localparam logic [XLEN-1:0] OFF_TIME_LO = 32'h0000_BFF8;
    localparam logic [XLEN-1:0] OFF_TIME_HI = 32'h0000_BFFC;

    localparam logic [1:0] BSEL_CMP_LO  = 2'b00;
    localparam logic [1:0] BSEL_CMP_HI  = 2'b01;
    localparam logic [1:0] BSEL_TIME_LO = 2'b10;
    localparam logic [1:0] BSEL_TIME_HI = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    typedef struct packed {
        logic       msip;
        logic       timer;
        logic [1:0] bsel;
        logic       err;
    } dec_t;

    // mtime is read-only, so a write to either half is a fault like an unmapped hit.
    function automatic dec_t clint_decode(input logic [XLEN-1:0] addr,
                                          input logic [XLEN-1:0] base,
                                          input logic            wen);
        dec_t            d;
        logic [XLEN-1:0] off;
        off = addr - base;
        d   = '0;
        case (off)
            OFF_MSIP: begin
                d.msip = 1'b1;
            end
            OFF_CMP_LO: begin
                d.timer = 1'b1;
                d.bsel  = BSEL_CMP_LO;
            end
            OFF_CMP_HI: begin
                d.timer = 1'b1;
                d.bsel  = BSEL_CMP_HI;
            end
            OFF_TIME_LO: begin
                d.timer = 1'b1;
                d.bsel  = BSEL_TIME_LO;
                d.err   = wen;
            end
            OFF_TIME_HI: begin
                d.timer = 1'b1;
                d.bsel  = BSEL_TIME_HI;
                d.err   = wen;
            end
            default: begin
                d.err = 1'b1;
            end
        endcase
        d.err = d.err | (addr[1:0] != 2'b00);
        return d;
    endfunction

endpackage

// File: rtl/lieat_rr_arb2.sv
// Two-way round-robin arbiter with one-hot grant; the last-grant pointer resets
// to requester 1 so requester 0 wins the first tie.
module lieat_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    // Grant selection: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer next state: follows every grant
    always_comb begin
        if (gnt_o != 2'b00) begin
            last_d = gnt_o[1];
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/lieat_clint_ctrl.sv
// CLINT bus controller: round-robin arbitration of two requesters onto the CLINT
// register port, address decode to strobes, one registered response per access.
module lieat_clint_ctrl
    import lieat_clint_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE = 32'h0200_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic [XLEN-1:0] m0_req_addr,
    input  logic            m0_req_wen,
    input  logic [XLEN-1:0] m0_req_wdata,
    output logic            m0_rsp_valid,
    input  logic            m0_rsp_ready,
    output logic [XLEN-1:0] m0_rsp_rdata,
    output logic            m0_rsp_err,
    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic [XLEN-1:0] m1_req_addr,
    input  logic            m1_req_wen,
    input  logic [XLEN-1:0] m1_req_wdata,
    output logic            m1_rsp_valid,
    input  logic            m1_rsp_ready,
    output logic [XLEN-1:0] m1_rsp_rdata,
    output logic            m1_rsp_err,
    output logic            clint_timeset_wen,
    output logic [1:0]      clint_timeset_bsel,
    output logic [XLEN-1:0] clint_timeset_wdata,
    input  logic [XLEN-1:0] clint_timeset_rdata,
    output logic            clint_msipset_wen,
    output logic [XLEN-1:0] clint_msipset_wdata,
    input  logic [XLEN-1:0] clint_msipset_rdata
);

    state_e          state_q;
    state_e          state_d;
    logic            owner_q;
    logic            owner_d;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_d;
    logic            err_q;
    logic            err_d;

    logic [1:0]      req_s;
    logic [1:0]      gnt_s;
    logic            grant_s;
    logic            sel_s;
    logic [XLEN-1:0] addr_s;
    logic            wen_s;
    logic [XLEN-1:0] wdata_s;
    logic            rsp_ready_s;
    dec_t            dec_s;

    // Requests reach the arbiter only while no response is outstanding
    always_comb begin
        if (state_q == ST_IDLE) begin
            req_s = {m1_req_valid, m0_req_valid};
        end else begin
            req_s = 2'b00;
        end
    end

    lieat_rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req_i (req_s),
        .gnt_o (gnt_s)
    );

    // Winner mux and decode; with no grant the m0 request drives bsel/wdata
    always_comb begin
        grant_s = (gnt_s != 2'b00);
        sel_s   = gnt_s[1];
        if (sel_s) begin
            addr_s  = m1_req_addr;
            wen_s   = m1_req_wen;
            wdata_s = m1_req_wdata;
        end else begin
            addr_s  = m0_req_addr;
            wen_s   = m0_req_wen;
            wdata_s = m0_req_wdata;
        end
        rsp_ready_s = owner_q ? m1_rsp_ready : m0_rsp_ready;
        dec_s       = clint_decode(addr_s, BASE, wen_s);
    end

    // State, owner and response registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next state: capture the access result on grant, hold it until the owner takes it
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_RESP;
                    owner_d = sel_s;
                    err_d   = dec_s.err;
                    if (dec_s.err || wen_s) begin
                        rdata_d = '0;
                    end else if (dec_s.msip) begin
                        rdata_d = clint_msipset_rdata;
                    end else begin
                        rdata_d = clint_timeset_rdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (rsp_ready_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: handshakes from grant/state, strobes only for a clean granted write
    always_comb begin
        m0_req_ready        = gnt_s[0];
        m1_req_ready        = gnt_s[1];
        m0_rsp_valid        = (state_q == ST_RESP) && !owner_q;
        m1_rsp_valid        = (state_q == ST_RESP) && owner_q;
        m0_rsp_rdata        = rdata_q;
        m1_rsp_rdata        = rdata_q;
        m0_rsp_err          = err_q;
        m1_rsp_err          = err_q;
        clint_timeset_wen   = grant_s && wen_s && dec_s.timer && !dec_s.err;
        clint_msipset_wen   = grant_s && wen_s && dec_s.msip && !dec_s.err;
        clint_timeset_bsel  = dec_s.bsel;
        clint_timeset_wdata = wdata_s;
        clint_msipset_wdata = wdata_s;
    end

endmodule
